// File: rtl/truth_table_capture.sv
// Observes a switch bus and a DUT output, captures y per settled pattern into a truth table,
// and reports pass/fail once every pattern is seen. Optional macro: TT_CONFLICT_DETECT_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// TRACK  | debouncing sw_in and capturing y_in per settled pattern
// DONE   | table complete, outputs frozen until start or reset
module truth_table_capture #(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_IN-1:0]      sw_in,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [2**N_IN-1:0]   seen,
  output logic [2**N_IN-1:0]   mismatch,
  output logic                 conflict
);

  localparam int NT = 2**N_IN;
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] C_SAT = CW'(SETTLE);
  localparam logic [CW-1:0] C_PRE = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_sw_q;
  logic [CW-1:0]     r_cnt;
  logic [NT-1:0]     r_table;
  logic [NT-1:0]     r_seen;
  logic              r_pass;
  logic              r_busy;
  logic              r_done;

  logic              w_stable;
  logic              w_capture;
  logic              w_all_seen;
  logic              w_conflict;

  assign w_stable   = (sw_in == r_sw_q);
  // Capture only on the edge that lifts cnt into saturation, so one capture per stable period.
  assign w_capture  = (r_state == S_TRACK) && w_stable && (r_cnt == C_PRE);
  assign w_all_seen = &r_seen;

`ifdef TT_CONFLICT_DETECT_EN
  logic r_conflict;
  logic w_conflict_hit;

  assign w_conflict_hit = w_capture && r_seen[r_sw_q] && (y_in != r_table[r_sw_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
    end else if (start) begin
      r_conflict <= 1'b0;
    end else if (w_conflict_hit) begin
      r_conflict <= 1'b1;
    end
  end

  assign w_conflict = r_conflict;
`else
  assign w_conflict = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sw_q  <= '0;
      r_cnt   <= '0;
      r_table <= '0;
      r_seen  <= '0;
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= S_TRACK;
      r_sw_q  <= sw_in;
      r_cnt   <= '0;
      r_table <= '0;
      r_seen  <= '0;
      r_pass  <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_TRACK: begin
          r_sw_q <= sw_in;
          if (!w_stable) begin
            r_cnt <= '0;
          end else if (r_cnt != C_SAT) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_capture) begin
            r_table[r_sw_q] <= y_in;
            r_seen[r_sw_q]  <= 1'b1;
          end
          if (w_all_seen) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_table == EXPECTED) && !w_conflict;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign table_out = r_table;
  assign seen      = r_seen;
  assign mismatch  = r_seen & (r_table ^ EXPECTED);
  assign conflict  = w_conflict;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: clean sweep, glitch rejection, wrong value,
// revisit/conflict, asynchronous reset mid-sweep and restart mid-sweep.
module tb_truth_table_capture;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] sw_in;
  logic       y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] table_out;
  logic [7:0] seen;
  logic [7:0] mismatch;
  logic       conflict;

  int n_checks = 0;
  int n_fail   = 0;

  truth_table_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sw_in     (sw_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .table_out (table_out),
    .seen      (seen),
    .mismatch  (mismatch),
    .conflict  (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic maj(input logic [2:0] p);
    return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
  endfunction

  // Drive at the falling edge; hold for n rising edges, ending at a falling edge.
  task automatic apply(input logic [2:0] p, input logic y, input int n);
    sw_in = p;
    y_in  = y;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [2:0] p);
    sw_in = p;
    y_in  = maj(p);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sweep_maj(input logic [2:0] lo, input logic [2:0] hi);
    for (int p = int'(lo); p <= int'(hi); p++) apply(3'(p), maj(3'(p)), 6);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sw_in = 3'd0;
    y_in  = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy",     32'(busy),      32'h0);
    check_val("rst_done",     32'(done),      32'h0);
    check_val("rst_pass",     32'(pass),      32'h0);
    check_val("rst_table",    32'(table_out), 32'h0);
    check_val("rst_seen",     32'(seen),      32'h0);
    check_val("rst_conflict", 32'(conflict),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep, with done timing checked one cycle before and at completion.
    pulse_start(3'd0);
    check_val("clean_busy", 32'(busy), 32'h1);
    sweep_maj(3'd0, 3'd6);
    apply(3'd7, 1'b1, 5);
    check_val("clean_seen_full", 32'(seen), 32'hFF);
    check_val("clean_done_early", 32'(done), 32'h0);
    @(negedge clk);
    check_val("clean_done",     32'(done),      32'h1);
    check_val("clean_busy_off", 32'(busy),      32'h0);
    check_val("clean_table",    32'(table_out), 32'hE8);
    check_val("clean_pass",     32'(pass),      32'h1);
    check_val("clean_mismatch", 32'(mismatch),  32'h0);
    // Outputs hold in DONE while inputs wander.
    apply(3'd5, 1'b0, 7);
    check_val("done_hold_table", 32'(table_out), 32'hE8);
    check_val("done_hold_pass",  32'(pass),      32'h1);

    // Glitch rejection and the SETTLE / SETTLE+1 boundary.
    pulse_start(3'd3);
    apply(3'd3, 1'b1, 1);
    apply(3'd4, 1'b0, 6);
    check_val("glitch_seen", 32'(seen), 32'h10);
    check_val("glitch_done", 32'(done), 32'h0);
    apply(3'd5, 1'b1, 4);
    check_val("settle_short", 32'(seen), 32'h10);
    apply(3'd5, 1'b1, 1);
    check_val("settle_exact", 32'(seen), 32'h30);
    check_val("settle_table", 32'(table_out), 32'h20);

    // Wrong value at pattern 5.
    pulse_start(3'd0);
    sweep_maj(3'd0, 3'd4);
    apply(3'd5, 1'b0, 6);
    sweep_maj(3'd6, 3'd7);
    check_val("wrong_done",     32'(done),      32'h1);
    check_val("wrong_table",    32'(table_out), 32'hC8);
    check_val("wrong_mismatch", 32'(mismatch),  32'h20);
    check_val("wrong_pass",     32'(pass),      32'h0);

    // Revisit pattern 2 with a different y.
    pulse_start(3'd2);
    apply(3'd2, 1'b0, 6);
    apply(3'd6, 1'b1, 6);
    apply(3'd2, 1'b1, 6);
    sweep_maj(3'd0, 3'd1);
    sweep_maj(3'd3, 3'd5);
    apply(3'd7, 1'b1, 6);
    check_val("revisit_done",  32'(done),      32'h1);
    check_val("revisit_table", 32'(table_out), 32'hEC);
    check_val("revisit_pass",  32'(pass),      32'h0);
`ifdef TT_CONFLICT_DETECT_EN
    check_val("revisit_conflict", 32'(conflict), 32'h1);
`else
    check_val("revisit_conflict", 32'(conflict), 32'h0);
`endif

    // Asynchronous reset after four captures.
    pulse_start(3'd0);
    sweep_maj(3'd0, 3'd3);
    check_val("prereset_seen", 32'(seen), 32'h0F);
    rst_n = 1'b0;
    #1;
    check_val("async_busy",  32'(busy),      32'h0);
    check_val("async_seen",  32'(seen),      32'h0);
    check_val("async_table", 32'(table_out), 32'h0);
    check_val("async_done",  32'(done),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("after_reset_idle", 32'(busy), 32'h0);
    pulse_start(3'd0);
    sweep_maj(3'd0, 3'd7);
    check_val("post_reset_done", 32'(done), 32'h1);
    check_val("post_reset_pass", 32'(pass), 32'h1);

    // Restart mid-sweep after three captures.
    pulse_start(3'd0);
    sweep_maj(3'd0, 3'd2);
    check_val("prerestart_seen", 32'(seen), 32'h07);
    pulse_start(3'd0);
    check_val("restart_seen", 32'(seen), 32'h0);
    check_val("restart_busy", 32'(busy), 32'h1);
    sweep_maj(3'd0, 3'd7);
    check_val("restart_done",  32'(done),      32'h1);
    check_val("restart_table", 32'(table_out), 32'hE8);
    check_val("restart_pass",  32'(pass),      32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
